bus_copy_master: RTL and testbench
==================================

Name: bus_copy_master

Overview:
- Bus master that sits upstream of the Memory and Reg slaves on the shared ADDR_BUS/DATA_BUS.
- On a Start pulse it copies Len consecutive words from Memory into Reg.
- It drives the slave strobes (M_W/M_ON, R_W/R_ON) and the address bus, captures read data, and re-drives that data for the register write.
- It is the only master on the bus; no other block drives ADDR_BUS or the strobes.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 16, data bus width.
- MEM_RD_LAT, 1, cycles from M_ON assertion to valid Memory data on DATA_BUS (range 1..7).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Src_Addr  in  ADDR_W  first Memory address; latched on accepted Start.
- Dst_Addr  in  ADDR_W  first Reg address; latched on accepted Start.
- Len  in  8  word count; latched on accepted Start.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  sticky verify error (see Optional Feature); cleared by an accepted Start.
- M_W  out  1  Memory write strobe; always 0 in this block.
- M_ON  out  1  Memory select.
- R_W  out  1  Reg write strobe.
- R_ON  out  1  Reg select.
- ADDR_BUS  out  ADDR_W  bus address.
- DATA_BUS  inout  DATA_W  shared data bus; driven only in WR, high-Z otherwise.

Behaviour:
- Reset (async, RSTn=0): state IDLE; Busy, Done, Err, M_W, M_ON, R_W, R_ON = 0; ADDR_BUS = 0; DATA_BUS high-Z; internal counters and holding register = 0.
- States and transitions:
  - IDLE: Start=1 and Len!=0 -> RD. Start=1 and Len=0 -> FIN; no bus activity occurs.
  - RD: M_ON=1, ADDR_BUS=src. Held for MEM_RD_LAT+1 cycles. On the last cycle, DATA_BUS is sampled into the holding register -> WR.
  - WR: R_ON=1, R_W=1, ADDR_BUS=dst, DATA_BUS=holding register, for 1 cycle. Then src+1, dst+1, remaining-1. If remaining reaches 0 -> FIN, else -> RD.
  - FIN: Done=1 for 1 cycle, Busy=0 -> IDLE.
- Cost per word: MEM_RD_LAT+2 cycles. Total from Start to Done pulse: 1 + Len*(MEM_RD_LAT+2) cycles.
- Busy is 1 in RD and WR. It is 0 in IDLE and FIN.
- Start while Busy is ignored; latched parameters are unaffected.
- Start in the FIN cycle is also ignored.
- Addresses increment modulo 2^ADDR_W: 0xFFFF wraps to 0x0000 with no error.
- Mutual exclusion: M_ON and R_ON are never 1 in the same cycle. DATA_BUS is released (high-Z) in every non-WR cycle, including the cycle after WR.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-transfer: bus released immediately, strobes deasserted asynchronously, no Done pulse. Partially copied words stay in Reg.
- Len=255 is the maximum; the counter does not wrap.

Optional Feature:
- Macro: BUS_COPY_VERIFY_EN.
- Enabled: after each WR, one extra VERIFY state is inserted.
  - VERIFY: R_ON=1, R_W=0, ADDR_BUS=dst, for MEM_RD_LAT+1 cycles.
  - DATA_BUS is sampled and compared to the holding register. A mismatch sets Err. Err stays set until the next accepted Start.
  - Transfer continues regardless of mismatch.
  - Per-word cost becomes 2*MEM_RD_LAT+3 cycles.
- Disabled: no VERIFY state; Err is tied to 0.

Test Plan:
- Reset: RSTn=0 mid-RD -> all strobes 0 and DATA_BUS=Z in the same cycle. After RSTn=1: IDLE, Busy=0, Done=0.
- Single word (MEM_RD_LAT=1): Memory[0x0010]=0xBEEF; Start, Src=0x0010, Dst=0x0003, Len=1.
  - Expect M_ON for 2 cycles with ADDR=0x0010, then 1 WR cycle with ADDR=0x0003, DATA=0xBEEF.
  - Expect Done at cycle 4 after Start and Reg[3]=0xBEEF.
- Burst with wrap: Src=0xFFFE, Dst=0x0000, Len=4.
  - Expect reads from 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order, and Reg[0..3] equal to those words.
  - Expect Busy high for 12 cycles and a single Done pulse.
- Len=0: Start -> Done pulse on the next cycle, M_ON/R_ON never asserted, Busy stays 0.
- Start ignored while busy: second Start with Src=0x0100 during a Len=3 transfer -> original addresses continue and exactly one Done pulse.
- Bus protocol checker (all tests): assertion that M_ON&R_ON never occurs, and that DATA_BUS is non-Z from this block only while R_W=1.
- VERIFY (BUS_COPY_VERIFY_EN defined): Reg model forced to return 0x0000 on readback of a 0x1234 write -> Err=1 after that word, transfer completes, Err clears on the next Start.

Source files
------------

// File: rtl/bus_copy_master.sv
// bus_copy_master: single bus master that copies Len words from Memory to Reg over ADDR_BUS/DATA_BUS.
// Define BUS_COPY_VERIFY_EN to add a readback check of every written word (drives the sticky Err flag).
module bus_copy_master #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Src_Addr,
    input  logic [ADDR_W-1:0] Dst_Addr,
    input  logic [7:0]        Len,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic              M_W,
    output logic              M_ON,
    output logic              R_W,
    output logic              R_ON,
    output logic [ADDR_W-1:0] ADDR_BUS,
    inout  wire  [DATA_W-1:0] DATA_BUS
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_VFY  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Cycle index (0-based) at which slave read data is valid and sampled.
    localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] src_r, src_s, dst_r, dst_s;
    logic [7:0]        rem_r, rem_s;
    logic [2:0]        cnt_r, cnt_s;
    logic [DATA_W-1:0] hold_r, hold_s;
    logic              accept_s, advance_s;

    logic              busy_r, busy_s, done_r, done_s;
    logic              m_on_r, m_on_s, r_on_r, r_on_s, r_w_r, r_w_s, drv_r, drv_s;
    logic [ADDR_W-1:0] addr_r, addr_s;

`ifdef BUS_COPY_VERIFY_EN
    logic              err_r, err_s;
`endif

    assign accept_s = (state_r == ST_IDLE) && Start;

    // Next-state sequencing and per-state phase counter / read-data capture
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        hold_s    = hold_r;
        advance_s = 1'b0;
`ifdef BUS_COPY_VERIFY_EN
        err_s     = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    cnt_s = 3'd0;
`ifdef BUS_COPY_VERIFY_EN
                    err_s = 1'b0;
`endif
                    if (Len == 8'd0) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r == LAT_LAST) begin
                    hold_s  = DATA_BUS;
                    cnt_s   = 3'd0;
                    state_s = ST_WR;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_WR: begin
`ifdef BUS_COPY_VERIFY_EN
                state_s = ST_VFY;
`else
                advance_s = 1'b1;
`endif
            end
            ST_VFY: begin
`ifdef BUS_COPY_VERIFY_EN
                if (cnt_r == LAT_LAST) begin
                    if (DATA_BUS != hold_r) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    cnt_s     = 3'd0;
                    advance_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        // The last bus phase of a word decides between the next word and completion.
        if (advance_s) begin
            if (rem_r == 8'd1) begin
                state_s = ST_FIN;
            end else begin
                state_s = ST_RD;
            end
        end else begin
            cnt_s = cnt_s;
        end
    end

    // Transfer context: latch on accepted Start, step after each completed word
    always_comb begin
        if (accept_s) begin
            src_s = Src_Addr;
            dst_s = Dst_Addr;
            rem_s = Len;
        end else if (advance_s) begin
            src_s = src_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            dst_s = dst_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            rem_s = rem_r - 8'd1;
        end else begin
            src_s = src_r;
            dst_s = dst_r;
            rem_s = rem_r;
        end
    end

    // Bus outputs for the state being entered, so the output flops match the state register
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        m_on_s = 1'b0;
        r_on_s = 1'b0;
        r_w_s  = 1'b0;
        drv_s  = 1'b0;
        addr_s = {ADDR_W{1'b0}};
        case (state_s)
            ST_RD: begin
                busy_s = 1'b1;
                m_on_s = 1'b1;
                addr_s = src_s;
            end
            ST_WR: begin
                busy_s = 1'b1;
                r_on_s = 1'b1;
                r_w_s  = 1'b1;
                drv_s  = 1'b1;
                addr_s = dst_s;
            end
            ST_VFY: begin
                busy_s = 1'b1;
                r_on_s = 1'b1;
                addr_s = dst_s;
            end
            ST_FIN:  done_s = 1'b1;
            default: done_s = 1'b0;
        endcase
    end

    // State, transfer context and registered bus outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
            src_r   <= {ADDR_W{1'b0}};
            dst_r   <= {ADDR_W{1'b0}};
            rem_r   <= 8'd0;
            cnt_r   <= 3'd0;
            hold_r  <= {DATA_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            m_on_r  <= 1'b0;
            r_on_r  <= 1'b0;
            r_w_r   <= 1'b0;
            drv_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            rem_r   <= rem_s;
            cnt_r   <= cnt_s;
            hold_r  <= hold_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            m_on_r  <= m_on_s;
            r_on_r  <= r_on_s;
            r_w_r   <= r_w_s;
            drv_r   <= drv_s;
            addr_r  <= addr_s;
        end
    end

`ifdef BUS_COPY_VERIFY_EN
    // Sticky readback mismatch flag
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end
    assign Err = err_r;
`else
    assign Err = 1'b0;
`endif

    assign Busy     = busy_r;
    assign Done     = done_r;
    assign M_W      = 1'b0;
    assign M_ON     = m_on_r;
    assign R_W      = r_w_r;
    assign R_ON     = r_on_r;
    assign ADDR_BUS = addr_r;
    assign DATA_BUS = drv_r ? hold_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_copy_master.sv
// tb_bus_copy_master: directed and randomized copies checked against a word-level copy model,
// with Memory/Reg slave models sharing DATA_BUS. Honours BUS_COPY_VERIFY_EN for timing and Err.
module tb_bus_copy_master;

    localparam int LAT = 1;
`ifdef BUS_COPY_VERIFY_EN
    localparam int PW = 2 * LAT + 3;
`else
    localparam int PW = LAT + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_addr = 16'h0000, dst_addr = 16'h0000;
    logic [7:0]  len = 8'd0;
    logic        busy, done, err, m_w, m_on, r_w, r_on;
    logic [15:0] addr_bus;
    wire  [15:0] data_bus;

    bus_copy_master #(.ADDR_W(16), .DATA_W(16), .MEM_RD_LAT(LAT)) dut (
        .CLK(clk), .RSTn(rst_n), .Start(start), .Src_Addr(src_addr), .Dst_Addr(dst_addr),
        .Len(len), .Busy(busy), .Done(done), .Err(err), .M_W(m_w), .M_ON(m_on),
        .R_W(r_w), .R_ON(r_on), .ADDR_BUS(addr_bus), .DATA_BUS(data_bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem  [0:65535];
    logic [15:0] regs [0:65535];
    int          rd_cyc = 0, vf_cyc = 0;
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = 16'h0000;
    logic [15:0] tb_val;

    // Slave side: data valid LAT cycles into a select; otherwise the bench holds a 0 probe value
    always_comb begin
        tb_val = 16'h0000;
        if (m_on && rd_cyc >= LAT) tb_val = mem[addr_bus];
        else if (r_on && !r_w && vf_cyc >= LAT)
            tb_val = (corrupt_en && addr_bus == corrupt_addr) ? 16'h0000 : regs[addr_bus];
    end
    assign data_bus = r_w ? 16'hzzzz : tb_val;

    always @(posedge clk) begin
        rd_cyc <= m_on ? rd_cyc + 1 : 0;
        vf_cyc <= (r_on && !r_w) ? vf_cyc + 1 : 0;
    end

    int          busy_cnt, done_cnt, m_on_cnt, viol;
    logic [15:0] rd_q[$], wa_q[$], wd_q[$];
    int          nvec = 0, nerr = 0;

    // Bus observer and Reg write model, sampled mid-cycle
    always @(negedge clk) begin
        if (m_on && rd_cyc == 0) rd_q.push_back(addr_bus);
        if (r_w) begin
            wa_q.push_back(addr_bus);
            wd_q.push_back(data_bus);
            regs[addr_bus] = data_bus;
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (m_on) m_on_cnt++;
        if (m_on && r_on) viol++;
        if (m_w) viol++;
        if (r_w && !r_on) viol++;
        if (!r_w && data_bus !== tb_val) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        busy_cnt = 0; done_cnt = 0; m_on_cnt = 0; viol = 0;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    // One copy: intr_at>0 pulses a competing Start in that cycle (cycle 1 = first after Start)
    task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input int n_words,
                            input int intr_at, input logic exp_err);
        int n, done_at, exp_done;
        logic [15:0] a;
        exp_done = 1 + n_words * PW;
        @(posedge clk); #1;
        clear_obs();
        start = 1'b1; src_addr = src; dst_addr = dst; len = 8'(n_words);
        n = 0; done_at = -1;
        while (n < 5000 && done_at < 0) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk("err_clr", {31'd0, err}, 32'd0);
            end
            if (n == intr_at) begin
                start = 1'b1; src_addr = 16'h0100; dst_addr = 16'h0700; len = 8'd9;
            end else if (n == intr_at + 1) begin
                start = 1'b0;
            end
            if (done) done_at = n;
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("done_cycle", done_at, exp_done);
        chk("done_pulses", done_cnt, 32'd1);
        chk("busy_cycles", busy_cnt, n_words * PW);
        chk("m_on_cycles", m_on_cnt, n_words * (LAT + 1));
        chk("protocol", viol, 32'd0);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("rd_count", rd_q.size(), n_words);
        chk("wr_count", wa_q.size(), n_words);
        for (int i = 0; i < n_words && i < rd_q.size() && i < wa_q.size(); i++) begin
            a = src + 16'(i);
            chk("rd_addr", rd_q[i], a);
            chk("wr_data", wd_q[i], mem[a]);
            chk("wr_addr", wa_q[i], dst + 16'(i));
            chk("reg_word", regs[dst + 16'(i)], mem[a]);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 16'($urandom_range(1, 65535));
            regs[i] = 16'h0000;
        end
        mem[16'h0010] = 16'hBEEF;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobes", {28'd0, m_w, m_on, r_w, r_on}, 32'd0);
        chk("rst_addr", addr_bus, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single word, burst across the address wrap, empty copy
        run_copy(16'h0010, 16'h0003, 1, 0, 1'b0);
        chk("reg3_beef", regs[3], 32'h0000BEEF);
        run_copy(16'hFFFE, 16'h0000, 4, 0, 1'b0);
        run_copy(16'h0020, 16'h0030, 0, 0, 1'b0);

        // Start during RD/WR and during the FIN cycle must both be ignored
        run_copy(16'h0500, 16'h0600, 3, 4, 1'b0);
        run_copy(16'h0540, 16'h0640, 3, 1 + 3 * PW, 1'b0);

        // Reset in the middle of a read phase
        @(posedge clk); #1;
        clear_obs();
        start = 1'b1; src_addr = 16'h0800; dst_addr = 16'h0900; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10 && !m_on; k++) begin @(posedge clk); #1; end
        chk("rst_mid_rd_seen", {31'd0, m_on}, 32'd1);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_mid_strobes", {28'd0, m_w, m_on, r_w, r_on}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_addr", addr_bus, 32'd0);
        chk("rst_mid_bus", data_bus, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_done", {31'd0, done}, 32'd0);
        chk("rst_no_done", done_cnt, 32'd0);
        chk("rst_protocol", viol, 32'd0);

        // Randomized copies, plus the longest transfer
        for (int t = 0; t < 8; t++)
            run_copy(16'($urandom), 16'($urandom), (t == 3) ? 0 : int'($urandom_range(1, 24)), 0, 1'b0);
        run_copy(16'($urandom), 16'h1000, 255, 0, 1'b0);

`ifdef BUS_COPY_VERIFY_EN
        // Corrupted readback of one word sets Err; the copy still completes; next Start clears it
        mem[16'h2001] = 16'h1234;
        corrupt_en = 1'b1; corrupt_addr = 16'h3001;
        run_copy(16'h2000, 16'h3000, 3, 0, 1'b1);
        corrupt_en = 1'b0;
        run_copy(16'h2000, 16'h3000, 1, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
